// File: rtl/gate_exer_pkg.sv
// rtl/gate_exer_pkg.sv - shared FSM state type and expected-response function for gate exercisers
package gate_exer_pkg;

  localparam int GE_MAX_N = 32;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  // Swap this function to exercise a different gate type; vectors are zero-extended to GE_MAX_N.
  function automatic logic [GE_MAX_N-1:0] expected_resp(input logic [GE_MAX_N-1:0] pattern);
    return ~pattern;
  endfunction

endpackage

// File: rtl/gate_exer_if.sv
// rtl/gate_exer_if.sv - stimulus/response and status bundle between exerciser and gate bench
interface gate_exer_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] dut_b;
  logic [N-1:0] drive_a;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   err_count;
  logic [N-1:0] first_fail;

  modport master (
    input  start, dut_b,
    output drive_a, busy, done, pass, err_count, first_fail
  );

  modport slave (
    output start, dut_b,
    input  drive_a, busy, done, pass, err_count, first_fail
  );
endinterface

// File: rtl/gate_exer_settle_cnt.sv
// rtl/gate_exer_settle_cnt.sv - SETTLE-cycle down-counter with load and zero flag
module gate_exer_settle_cnt #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int            CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] cnt;

  // Loading SETTLE-1 makes the zero flag rise on the SETTLE-th enabled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - ONE;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_exerciser.sv
// rtl/gate_exerciser.sv - sweeps all 2^N patterns into a bus-inverter gate and checks its response (option: GATE_EXER_STOP_ON_FAIL_EN)
module gate_exerciser
  import gate_exer_pkg::*;
#(
  parameter int N      = 4,
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  gate_exer_if.master bus
);

  localparam logic [GE_MAX_N-1:0] MASK = {GE_MAX_N{1'b1}} >> (GE_MAX_N - N);
  localparam logic [N:0]          ONE  = (N + 1)'(1);

  state_t              state;
  logic [GE_MAX_N-1:0] pat_ext;
  logic [GE_MAX_N-1:0] dut_ext;
  logic [GE_MAX_N-1:0] exp_ext;
  logic                mismatch;
  logic                last_pat;
  logic                to_done;
  logic                cnt_load;
  logic                cnt_zero;

  always_comb begin
    pat_ext          = '0;
    pat_ext[N-1:0]   = bus.drive_a;
    dut_ext          = '0;
    dut_ext[N-1:0]   = bus.dut_b;
  end

  assign exp_ext  = expected_resp(pat_ext);
  assign mismatch = |((dut_ext ^ exp_ext) & MASK);
  // drive_a doubles as the pattern index: both start at 0 and step together.
  assign last_pat = &bus.drive_a;

`ifdef GATE_EXER_STOP_ON_FAIL_EN
  assign to_done = last_pat | mismatch;
`else
  assign to_done = last_pat;
`endif

  assign cnt_load = ((state == IDLE) && bus.start) || ((state == CHECK) && !to_done);

  gate_exer_settle_cnt #(
    .SETTLE (SETTLE)
  ) u_settle_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (state == DRIVE),
    .zero (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      bus.drive_a    <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.pass       <= 1'b0;
      bus.err_count  <= '0;
      bus.first_fail <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state          <= DRIVE;
            bus.busy       <= 1'b1;
            bus.drive_a    <= '0;
            bus.err_count  <= '0;
            bus.first_fail <= '0;
          end
        end
        DRIVE: begin
          if (cnt_zero) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (mismatch) begin
            bus.err_count <= bus.err_count + ONE;
            if (bus.err_count == '0) begin
              bus.first_fail <= bus.drive_a;
            end
          end
          if (to_done) begin
            // pass is resolved here so it is already valid alongside the done pulse.
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= !mismatch && (bus.err_count == '0);
          end else begin
            state       <= DRIVE;
            bus.drive_a <= bus.drive_a + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// tb/tb_gate_exerciser.sv - randomized and directed self-checking bench for gate_exerciser
module tb_gate_exerciser;

  localparam int N      = 4;
  localparam int SETTLE = 2;
  localparam int NPAT   = 1 << N;
  localparam int LIMIT  = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;

  gate_exer_if #(.N(N)) bus ();

  gate_exerciser #(.N(N), .SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Faulty-gate model: stuck-at masks plus a per-pattern flip table.
  logic [N-1:0] sa0;
  logic [N-1:0] sa1;
  logic [N-1:0] flip_tbl [NPAT];

  assign bus.dut_b = (((~bus.drive_a) & ~sa0) | sa1) ^ flip_tbl[bus.drive_a];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] gate_resp(input int p);
    logic [N-1:0] pv;
    pv = N'(p);
    return (((~pv) & ~sa0) | sa1) ^ flip_tbl[p];
  endfunction

  // Expected sweep outcome from the rules: done cycle, mismatch count, first failing pattern.
  task automatic model(output int len, output int err, output int ff, output int ps);
    int npat;
    logic [N-1:0] inv;
    err  = 0;
    ff   = 0;
    npat = 0;
    for (int p = 0; p < NPAT; p++) begin
      npat++;
      inv = ~N'(p);
      if (gate_resp(p) != inv) begin
        if (err == 0) ff = p;
        err++;
`ifdef GATE_EXER_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
    len = 1 + npat * (SETTLE + 1);
    ps  = (err == 0) ? 1 : 0;
  endtask

  task automatic run_sweep(input string tag, input bit hold, input bit mid_start);
    int len, err, ff, ps, cyc;
    model(len, err, ff, ps);
    bus.start = 1'b1;
    tick();
    if (!hold) bus.start = 1'b0;
    cyc = 1;
    chk({tag, ".busy_on"}, 32'(bus.busy), 1);
    while (!bus.done && cyc < LIMIT) begin
      chk({tag, ".drive_a"}, 32'(bus.drive_a), 32'((cyc - 1) / (SETTLE + 1)));
      if (mid_start && cyc == 20) bus.start = 1'b1;
      if (mid_start && cyc == 21) bus.start = 1'b0;
      tick();
      cyc++;
    end
    chk({tag, ".done_cycle"}, 32'(cyc), 32'(len));
    chk({tag, ".busy_off"}, 32'(bus.busy), 0);
    chk({tag, ".err_count"}, 32'(bus.err_count), 32'(err));
    chk({tag, ".first_fail"}, 32'(bus.first_fail), 32'(ff));
    tick();
    chk({tag, ".done_pulse"}, 32'(bus.done), 0);
    chk({tag, ".pass"}, 32'(bus.pass), 32'(ps));
    chk({tag, ".err_hold"}, 32'(bus.err_count), 32'(err));
  endtask

  task automatic clear_faults();
    sa0 = '0;
    sa1 = '0;
    for (int i = 0; i < NPAT; i++) flip_tbl[i] = '0;
  endtask

  initial begin
    int cyc, pulses;
    clear_faults();
    bus.start = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("reset.drive_a", 32'(bus.drive_a), 0);
    chk("reset.busy", 32'(bus.busy), 0);
    chk("reset.done", 32'(bus.done), 0);
    chk("reset.pass", 32'(bus.pass), 0);
    chk("reset.err_count", 32'(bus.err_count), 0);
    chk("reset.first_fail", 32'(bus.first_fail), 0);
    rst = 1'b0;
    tick();

    run_sweep("ideal", 1'b0, 1'b0);

    sa0 = N'(1);
    run_sweep("bit0_sa0", 1'b0, 1'b0);
    clear_faults();

    sa1 = N'(8);
    run_sweep("bit3_sa1", 1'b0, 1'b0);
    clear_faults();

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NPAT; i++)
        flip_tbl[i] = ($urandom_range(0, 3) == 0) ? N'($urandom_range(1, NPAT - 1)) : '0;
      run_sweep("random", 1'b0, 1'b0);
    end
    clear_faults();

    // Held start: one sweep per IDLE entry, back to back.
    run_sweep("held_a", 1'b1, 1'b0);
    chk("held.idle_gap", 32'(bus.busy), 0);
    run_sweep("held_b", 1'b1, 1'b0);
    bus.start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.busy || bus.done) pulses++;
    end
    chk("held.stays_idle", 32'(pulses), 0);

    run_sweep("mid_start", 1'b0, 1'b1);

    // Reset during CHECK of pattern 5 of a failing sweep.
    run_sweep("pre_reset", 1'b0, 1'b0);
    sa0 = N'(1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 5 * (SETTLE + 1) + (SETTLE + 1)) begin
      tick();
      cyc++;
    end
    chk("midrst.pattern", 32'(bus.drive_a), 5);
    chk("midrst.err_before", 32'(bus.err_count), 3);
    rst = 1'b1;
    #1;
    chk("midrst.drive_a", 32'(bus.drive_a), 0);
    chk("midrst.busy", 32'(bus.busy), 0);
    chk("midrst.done", 32'(bus.done), 0);
    chk("midrst.pass", 32'(bus.pass), 0);
    chk("midrst.err_count", 32'(bus.err_count), 0);
    chk("midrst.first_fail", 32'(bus.first_fail), 0);
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.done || bus.busy) pulses++;
    end
    chk("midrst.no_done", 32'(pulses), 0);
    clear_faults();
    run_sweep("post_reset", 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
